reel_sequencer: RTL

Sequences the three slot-machine reels for one spin round. On a lever pull it spins all reels, then stops them one after another with a fast-to-slow deceleration. When all reels have stopped it reports the final symbols and a win flag. It sits between the lever/debounce logic and the top-level game FSM; that FSM consumes done/win to choose its win or lose state.

---
 rtl/reel_pkg.sv | 19 +
 rtl/reel_stepper.sv | 73 +++++++
 rtl/reel_sequencer.sv | 113 +++++++++++
 3 files changed

// File: rtl/reel_pkg.sv
// Shared reel-sequencer types and constants: FSM state encoding, LFSR seed/taps, reel count.
package reel_pkg;

  localparam int          NUM_REELS = 3;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SPIN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/reel_stepper.sv
// One reel: clock divider, remaining-step counter and wrapping symbol counter.
module reel_stepper #(
  parameter int NUM_SYMBOLS = 8,
  parameter int SYM_W       = 3,
  parameter int FAST_TICKS  = 2_000_000,
  parameter int SLOW_TICKS  = 6_000_000,
  parameter int SLOW_STEPS  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [7:0]       budget,
  input  logic             attract,
  output logic [SYM_W-1:0] sym,
  output logic             moving,
  output logic             step
);

  localparam int               DIV_W     = $clog2(SLOW_TICKS);
  localparam logic [DIV_W-1:0] FAST_LAST = DIV_W'(FAST_TICKS - 1);
  localparam logic [DIV_W-1:0] SLOW_LAST = DIV_W'(SLOW_TICKS - 1);
  localparam logic [7:0]       SLOW_N    = 8'(SLOW_STEPS);
  localparam logic [SYM_W-1:0] SYM_MAX   = SYM_W'(NUM_SYMBOLS - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       rem_q, rem_d;
  logic [SYM_W-1:0] sym_q, sym_d;
  logic             step_q, step_d;
  logic             active;
  logic [DIV_W-1:0] last;

  always_comb begin
    active = (rem_q != 8'd0) | attract;
    // Idle crawl (rem == 0) always runs at the slow rate.
    last   = (rem_q > SLOW_N) ? FAST_LAST : SLOW_LAST;
    div_d  = div_q;
    rem_d  = rem_q;
    sym_d  = sym_q;
    step_d = 1'b0;
    if (load) begin
      div_d = '0;
      rem_d = budget;
    end else if (active) begin
      if (div_q == last) begin
        div_d  = '0;
        step_d = 1'b1;
        sym_d  = (sym_q == SYM_MAX) ? '0 : sym_q + 1'b1;
        if (rem_q != 8'd0) rem_d = rem_q - 8'd1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q  <= '0;
      rem_q  <= '0;
      sym_q  <= '0;
      step_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      rem_q  <= rem_d;
      sym_q  <= sym_d;
      step_q <= step_d;
    end
  end

  assign sym    = sym_q;
  assign moving = (rem_q != 8'd0);
  assign step   = step_q;

endmodule

// File: rtl/reel_sequencer.sv
// Three-reel spin sequencer: staggered fast-to-slow stops, done pulse and win flag.
// Define REEL_ATTRACT_EN to let the reels crawl at the slow rate while idle.
module reel_sequencer
  import reel_pkg::*;
#(
  parameter int         NUM_SYMBOLS   = 8,
  parameter int         SYM_W         = 3,
  parameter int         FAST_TICKS    = 2_000_000,
  parameter int         SLOW_TICKS    = 6_000_000,
  parameter int         SPIN_STEPS    = 24,
  parameter int         STAGGER_STEPS = 8,
  parameter int         SLOW_STEPS    = 4,
  parameter logic [2:0] OFFSET_MASK   = 3'b111
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 go,
  output logic                 busy,
  output logic [SYM_W-1:0]     reel_sym0,
  output logic [SYM_W-1:0]     reel_sym1,
  output logic [SYM_W-1:0]     reel_sym2,
  output logic [NUM_REELS-1:0] reel_moving,
  output logic [NUM_REELS-1:0] reel_step,
  output logic                 done,
  output logic                 win
);

  state_e                            state_q, state_d;
  logic                              go_q;
  logic [15:0]                       lfsr_q, lfsr_d;
  logic                              win_q, win_d;
  logic                              go_edge, load, attract;
  logic [NUM_REELS-1:0][7:0]         budget;
  logic [NUM_REELS-1:0][SYM_W-1:0]   sym;
  logic [NUM_REELS-1:0]              moving, step;

  assign go_edge = go & ~go_q;
  assign load    = (state_q == ST_IDLE) && go_edge;

`ifdef REEL_ATTRACT_EN
  assign attract = (state_q == ST_IDLE);
`else
  assign attract = 1'b0;
`endif

  always_comb begin
    budget = '0;
    for (int i = 0; i < NUM_REELS; i++)
      budget[i] = 8'(SPIN_STEPS + i * STAGGER_STEPS) + {5'b0, lfsr_q[3*i +: 3] & OFFSET_MASK};
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    lfsr_d  = lfsr_next(lfsr_q);
    case (state_q)
      ST_IDLE: if (go_edge) begin
        state_d = ST_SPIN;
        win_d   = 1'b0;
      end
      // win is captured as the last reel settles so it is valid alongside done.
      ST_SPIN: if (moving == '0) begin
        state_d = ST_DONE;
        win_d   = (sym[0] == sym[1]) && (sym[1] == sym[2]);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      go_q    <= 1'b0;
      lfsr_q  <= LFSR_SEED;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      go_q    <= go;
      lfsr_q  <= lfsr_d;
      win_q   <= win_d;
    end
  end

  for (genvar g = 0; g < NUM_REELS; g++) begin : g_reel
    reel_stepper #(
      .NUM_SYMBOLS (NUM_SYMBOLS),
      .SYM_W       (SYM_W),
      .FAST_TICKS  (FAST_TICKS),
      .SLOW_TICKS  (SLOW_TICKS),
      .SLOW_STEPS  (SLOW_STEPS)
    ) u_stepper (
      .clk     (clk),
      .reset   (reset),
      .load    (load),
      .budget  (budget[g]),
      .attract (attract),
      .sym     (sym[g]),
      .moving  (moving[g]),
      .step    (step[g])
    );
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign win         = win_q;
  assign reel_sym0   = sym[0];
  assign reel_sym1   = sym[1];
  assign reel_sym2   = sym[2];
  assign reel_moving = moving;
  assign reel_step   = step;

endmodule
